// File: rtl/pool1_rm_pkg.sv
// Shared definitions for the pool1 row-memory port: geometry, response type,
// arbitration side, and the address-legality helper used by arbiter and bench.
package pool1_rm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 9;
  localparam int RAM_WORDS  = 384;

  // One read response: data is forced to zero when err is set.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } rsp_t;

  // Which requester won the most recent contested grant.
  typedef enum logic {
    SIDE_WRITE = 1'b0,
    SIDE_READ  = 1'b1
  } side_e;

  // Addresses at or above RAM_WORDS do not exist in the macro.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(RAM_WORDS);
  endfunction

endpackage

// File: rtl/pool1_rm_rsp_fifo.sv
// Two-entry response queue for read data. Head is presented combinationally;
// the arbiter's credit scheme keeps pushes away from a full queue.
module pool1_rm_rsp_fifo
  import pool1_rm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rsp_t       push_data,
  input  logic       pop,
  output rsp_t       head,
  output logic       valid,
  output logic       full,
  output logic [1:0] count
);

  rsp_t       mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign valid  = (count != 2'd0);
  assign full   = (count == 2'd2);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; cleared by reset so contents are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (push)   wr_ptr <= ~wr_ptr;
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop_ok);
    end
  end

  // Entry storage; validity comes solely from count.
  // NOTE: storage is deliberately not reset; count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Upstream credit must never allow a push into a full queue.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/pool1_rm_port_arbiter.sv
// Round-robin sharer of the pool1 row-memory single RW port between a write
// producer and a read consumer. Drives SRAM pins in the grant cycle, captures
// read data one edge later into a 2-entry response queue, flags illegal addresses.
module pool1_rm_port_arbiter
  import pool1_rm_pkg::*;
(
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  err_oob,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  side_e      rr_last;
  side_e      rr_last_next;
  logic       inflight;
  logic       inflight_err;

  logic       q_valid;
  logic       q_full;
  logic [1:0] q_count;
  rsp_t       q_head;
  rsp_t       push_data;
  logic       pop;

  logic [1:0] occ;
  logic       credit;
  logic       rd_eligible;
  logic       contested;
  logic       wr_fire;
  logic       rd_fire;
  logic       wr_in_range;
  logic       rd_in_range;

  assign wr_in_range = addr_in_range(wr_addr);
  assign rd_in_range = addr_in_range(rd_addr);

  // Credit, round-robin grant and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    pop          = q_valid && rsp_ready;
    occ          = 2'(inflight) + q_count;
    credit       = (occ < 2'd2) || ((occ == 2'd2) && pop);
    rd_eligible  = rd_valid && credit;
    contested    = wr_valid && rd_eligible;
    // A side loses only when both are eligible and it was the previous contest winner.
    wr_ready     = !(rd_eligible && (rr_last == SIDE_WRITE));
    rd_ready     = credit && !(wr_valid && (rr_last == SIDE_READ));
    wr_fire      = wr_valid && wr_ready;
    rd_fire      = rd_valid && rd_ready;
    rr_last_next = rr_last;
    if (contested) rr_last_next = wr_fire ? SIDE_WRITE : SIDE_READ;
  end

  // SRAM pins follow the grant combinationally; illegal addresses leave the macro idle.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (wr_fire && wr_in_range) begin
      sram_csb0  = 1'b0;
      sram_web0  = 1'b0;
      sram_addr0 = wr_addr;
      sram_din0  = wr_data;
    end else if (rd_fire && rd_in_range) begin
      sram_csb0  = 1'b0;
      sram_addr0 = rd_addr;
    end
  end

  // Arbitration history, in-flight read tracking and the sticky range error.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rr_last      <= SIDE_READ;
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      rr_last      <= rr_last_next;
      inflight     <= rd_fire;
      inflight_err <= rd_fire && !rd_in_range;
      if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) err_oob <= 1'b1;
    end
  end

  // dout is only valid around the edge after the grant, so capture it right there.
  always_comb begin
    push_data.err  = inflight_err;
    push_data.data = inflight_err ? '0 : sram_dout0;
  end

  pool1_rm_rsp_fifo u_rsp_fifo (
    .clk       (clk0),
    .rst_n     (rst0_n),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .full      (q_full),
    .count     (q_count)
  );

  assign rsp_valid = q_valid;
  assign rsp_data  = q_valid ? q_head.data : '0;
  assign rsp_err   = q_valid && q_head.err;

endmodule

// File: tb/tb_pool1_rm_port_arbiter.sv
// Bench for pool1_rm_port_arbiter: behavioural single-port SRAM, a queue-based
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_pool1_rm_port_arbiter;
  import pool1_rm_pkg::*;

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [8:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        rsp_valid, rsp_ready, rsp_err, err_oob;
  logic [15:0] rsp_data;
  logic        sram_csb0, sram_web0;
  logic [8:0]  sram_addr0;
  logic [15:0] sram_din0, sram_dout0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk0 = ~clk0;

  pool1_rm_port_arbiter dut (
    .clk0       (clk0),
    .rst0_n     (rst0_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .err_oob    (err_oob),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // OpenRAM-style SRAM: pins latched at posedge, access on negedge, dout corrupted just after posedge.
  logic [15:0] sram_mem [RAM_WORDS];
  logic        s_csb, s_web;
  logic [8:0]  s_addr;
  logic [15:0] s_din;
  initial begin
    sram_dout0 = 16'hDEAD;
    forever begin
      @(posedge clk0);
      s_csb = sram_csb0; s_web = sram_web0; s_addr = sram_addr0; s_din = sram_din0;
      #1 sram_dout0 = 16'hDEAD;
      @(negedge clk0);
      if (!s_csb && (s_addr < 9'(RAM_WORDS))) begin
        if (!s_web) sram_mem[s_addr] = s_din;
        else        sram_dout0 = sram_mem[s_addr];
      end
    end
  end

  // Reference model: expected memory, responses awaiting capture, visible responses.
  typedef struct { logic [15:0] data; logic err; } exp_t;
  exp_t        m_q[$];
  exp_t        m_pend[$];
  logic [15:0] m_mem [RAM_WORDS];
  bit          m_last_write = 1'b0;
  bit          m_err = 1'b0;

  initial begin : model
    int  occ;
    bit  pop, credit, we, re, wf, rf, w_ok, r_ok;
    exp_t e;
    forever begin
      @(negedge clk0); #2;
      if (!rst0_n) begin
        m_q.delete(); m_pend.delete(); m_last_write = 1'b0; m_err = 1'b0;
        check("m_rst_rsp_valid", rsp_valid, 0);
        check("m_rst_rsp_data",  rsp_data,  0);
        check("m_rst_rsp_err",   rsp_err,   0);
        check("m_rst_err_oob",   err_oob,   0);
        @(posedge clk0);
      end else begin
        occ    = m_q.size() + m_pend.size();
        pop    = (m_q.size() > 0) && rsp_ready;
        credit = (occ < 2) || (occ == 2 && pop);
        we     = wr_valid;
        re     = rd_valid && credit;
        wf     = we && (!re || !m_last_write);
        rf     = re && !wf;
        w_ok   = wr_addr < 9'(RAM_WORDS);
        r_ok   = rd_addr < 9'(RAM_WORDS);
        check("m_wr_fire", wr_valid && wr_ready, wf);
        check("m_rd_fire", rd_valid && rd_ready, rf);
        if (wf && w_ok) begin
          check("m_w_csb", sram_csb0, 0); check("m_w_web", sram_web0, 0);
          check("m_w_addr", sram_addr0, wr_addr); check("m_w_din", sram_din0, wr_data);
        end else if (rf && r_ok) begin
          check("m_r_csb", sram_csb0, 0); check("m_r_web", sram_web0, 1);
          check("m_r_addr", sram_addr0, rd_addr);
        end else begin
          check("m_idle_csb", sram_csb0, 1); check("m_idle_web", sram_web0, 1);
          check("m_idle_addr", sram_addr0, 0); check("m_idle_din", sram_din0, 0);
        end
        check("m_rsp_valid", rsp_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          check("m_rsp_data", rsp_data, m_q[0].data);
          check("m_rsp_err",  rsp_err,  m_q[0].err);
        end
        check("m_err_oob", err_oob, m_err);
        @(posedge clk0);
        if (rst0_n) begin
          if (pop) void'(m_q.pop_front());
          while (m_pend.size() > 0) m_q.push_back(m_pend.pop_front());
          if (we && re) m_last_write = wf;
          if (wf && w_ok) m_mem[wr_addr] = wr_data;
          if ((wf && !w_ok) || (rf && !r_ok)) m_err = 1'b1;
          if (rf) begin
            e.data = r_ok ? m_mem[rd_addr] : 16'h0;
            e.err  = !r_ok;
            m_pend.push_back(e);
          end
        end
      end
    end
  end

  task automatic step_idle();
    @(negedge clk0); wr_valid = 1'b0; rd_valid = 1'b0; #3;
  endtask

  task automatic expect_rsp(input string name, input logic [15:0] data, input logic err);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step_idle();
      if (rsp_valid) begin
        seen = 1'b1;
        check({name, "_data"}, rsp_data, data);
        check({name, "_err"},  rsp_err,  err);
      end
    end
    if (!seen) check({name, "_timeout"}, rsp_valid, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin : directed
    rst0_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < RAM_WORDS; i++) begin sram_mem[i] = 16'h0; m_mem[i] = 16'h0; end
    repeat (3) @(negedge clk0);
    rst0_n = 1'b1;

    // 1: write then read back the same word.
    @(negedge clk0); wr_valid = 1'b1; wr_addr = 9'd5; wr_data = 16'h1234; #3;
    check("t1_wr_ready", wr_ready, 1); check("t1_csb0", sram_csb0, 0); check("t1_web0", sram_web0, 0);
    @(negedge clk0); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5; #3;
    check("t1_rd_ready", rd_ready, 1); check("t1_read_web0", sram_web0, 1);
    step_idle(); check("t1_rsp_early", rsp_valid, 0);
    step_idle(); check("t1_rsp_valid", rsp_valid, 1); check("t1_rsp_data", rsp_data, 16'h1234);
    step_idle();

    // 2: both sides always requesting -> W,R,W,R...
    for (int i = 0; i < 8; i++) begin
      @(negedge clk0);
      wr_valid = 1'b1; wr_addr = 9'(16 + i); wr_data = 16'(16'hB000 + i);
      rd_valid = 1'b1; rd_addr = 9'd16; #3;
      check("t2_wr_grant", wr_ready, (i % 2) == 0);
      check("t2_rd_grant", rd_ready, (i % 2) == 1);
      check("t2_one_csb", sram_csb0, 0);
    end
    repeat (3) step_idle();

    // 3: backpressure on responses, in-order return.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0); wr_valid = 1'b1; wr_addr = 9'(i); wr_data = 16'(16'hA000 + i); #3;
    end
    @(negedge clk0); wr_valid = 1'b0; rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd0; #3;
    check("t3_rd0_ready", rd_ready, 1);
    @(negedge clk0); rd_addr = 9'd1; #3;
    check("t3_rd1_ready", rd_ready, 1);
    @(negedge clk0); rd_addr = 9'd2; #3;
    check("t3_rd2_blocked", rd_ready, 0);
    @(negedge clk0); #3;
    check("t3_rd2_still_blocked", rd_ready, 0); check("t3_head_held", rsp_data, 16'hA000);
    @(negedge clk0); rsp_ready = 1'b1; #3;
    check("t3_rd2_ready", rd_ready, 1); check("t3_rsp0", rsp_data, 16'hA000);
    expect_rsp("t3_rsp1", 16'hA001, 1'b0);
    expect_rsp("t3_rsp2", 16'hA002, 1'b0);
    repeat (2) step_idle();

    // 4: out-of-range read.
    @(negedge clk0); rd_valid = 1'b1; rd_addr = 9'd400; #3;
    check("t4_rd_ready", rd_ready, 1); check("t4_csb_high", sram_csb0, 1);
    step_idle(); check("t4_err_oob_set", err_oob, 1);
    step_idle(); check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_err", rsp_err, 1); check("t4_rsp_data", rsp_data, 0);
    repeat (3) step_idle(); check("t4_err_oob_sticky", err_oob, 1);

    // 5: streaming reads, one per cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk0); rd_valid = 1'b1; rd_addr = 9'(i); #3;
      check("t5_stream_ready", rd_ready, 1);
    end
    repeat (4) step_idle();

    // 6: contest leaves rr_last at WRITE, then reset mid-flight restores write priority.
    @(negedge clk0); wr_valid = 1'b1; wr_addr = 9'd3; wr_data = 16'hC003;
    rd_valid = 1'b1; rd_addr = 9'd3; #3;
    check("t6_contest_w", wr_ready, 1); check("t6_contest_r", rd_ready, 0);
    @(negedge clk0); wr_valid = 1'b0; rsp_ready = 1'b0; #3;
    check("t6_rd_a", rd_ready, 1);
    @(negedge clk0); rd_addr = 9'd4; #3;
    check("t6_rd_b", rd_ready, 1);
    @(negedge clk0); rd_valid = 1'b0; #3;
    check("t6_pre_rsp", rsp_valid, 1); check("t6_pre_data", rsp_data, 16'hC003);
    #1 rst0_n = 1'b0;
    #1 check("t6_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk0); #3; check("t6_rst_hold", rsp_valid, 0);
    @(negedge clk0); rst0_n = 1'b1; rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'd7; wr_data = 16'h7777; rd_valid = 1'b1; rd_addr = 9'd7; #3;
    check("t6_first_w", wr_ready, 1); check("t6_first_r", rd_ready, 0);
    check("t6_err_cleared", err_oob, 0);
    @(negedge clk0); wr_valid = 1'b0; #3;
    check("t6_then_r", rd_ready, 1);
    expect_rsp("t6_rsp", 16'h7777, 1'b0);
    repeat (2) step_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
